// File: rtl/hft_egress_pkg.sv
// Shared types for the quote-pair egress path: one message is MSG_WORDS words of REG_WIDTH bits.
// No logic, no latency.
// No flow control here; types only.
package hft_egress_pkg;

    localparam int REG_WIDTH = 32;
    localparam int MSG_WORDS = 9;
    localparam int IDX_W     = $clog2(MSG_WORDS);

    typedef logic [REG_WIDTH-1:0] word_t;

    // Word k occupies bits [k*REG_WIDTH +: REG_WIDTH], so the flat port bus casts directly.
    typedef word_t [MSG_WORDS-1:0] msg_t;

    typedef struct packed {
        msg_t buy;
        msg_t sell;
    } pair_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND_BUY,
        SEND_SELL
    } egress_state_t;

endpackage

// File: rtl/egress_pair_fifo.sv
// Message-pair FIFO with occupancy tracking; a push into a full FIFO succeeds when a pop shares the edge.
// Latency: a pushed pair is readable at the head one cycle after the write edge.
// Backpressure: a refused push is reported through o_accept = 0; contents are left untouched.
module egress_pair_fifo
    import hft_egress_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_push,
    input  pair_t                         i_pair,
    input  logic                          i_pop,
    output logic                          o_accept,
    output pair_t                         o_head,
    output word_t                         o_next_buy0,
    output logic                          o_empty,
    output logic                          o_almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_occ
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PW + 1;
    localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] AFULL_OCC = OCC_W'(AFULL_LEVEL);

    pair_t             mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     rd_nxt;
    logic [OCC_W-1:0]  occ_q, occ_d;

    // When full, the write lands in the slot being popped; its old content is read before the edge.
    assign o_accept      = i_push & ((occ_q != FULL_OCC) | i_pop);
    assign rd_nxt        = rd_ptr_q + 1'b1;
    assign o_head        = mem[rd_ptr_q];
    assign o_next_buy0   = mem[rd_nxt].buy[0];
    assign o_empty       = (occ_q == '0);
    assign o_almost_full = (occ_q >= AFULL_OCC);
    assign o_occ         = occ_q;

    always_comb begin
        wr_ptr_d = o_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = i_pop    ? rd_nxt          : rd_ptr_q;
        unique case ({o_accept, i_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (o_accept) begin
            mem[wr_ptr_q] <= i_pair;
        end
    end

endmodule

// File: rtl/order_egress_serializer.sv
// Buffers quote pairs and streams them word-by-word (buy then sell, tlast per message); ORDER_EGRESS_STATS_EN adds counters.
// Latency: pair pushed into an empty FIFO at edge N is presented after edge N+1; pairs stream back-to-back.
// Backpressure: output regs hold under i_tready=0; pushes beyond FIFO_DEPTH are dropped with o_drop_pulse.
module order_egress_serializer
    import hft_egress_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_valid,
    input  logic [MSG_WORDS*REG_WIDTH-1:0] i_buy_words,
    input  logic [MSG_WORDS*REG_WIDTH-1:0] i_sell_words,
    output logic [REG_WIDTH-1:0]           o_tdata,
    output logic                           o_tvalid,
    output logic                           o_tlast,
    output logic                           o_tside,
    input  logic                           i_tready,
    output logic                           o_almost_full,
    output logic                           o_drop_pulse
`ifdef ORDER_EGRESS_STATS_EN
    ,
    output logic [31:0]                    o_pairs_sent,
    output logic [31:0]                    o_pairs_dropped
`endif
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_WORDS - 1);
    localparam logic             ONE_WORD = (MSG_WORDS == 1);

    egress_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              tside_q, tside_d;
    word_t             tdata_q, tdata_d;
    logic              drop_q;

    pair_t             in_pair, head;
    word_t             next_buy0;
    logic              push_accept, fifo_empty, pop, hs, at_last;
    logic [OCC_W-1:0]  fifo_occ;

    assign in_pair = {i_buy_words, i_sell_words};
    assign hs      = tvalid_q & i_tready;
    assign at_last = (idx_q == LAST_IDX);
    assign pop     = hs & (state_q == SEND_SELL) & at_last;

    egress_pair_fifo #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .AFULL_LEVEL (AFULL_LEVEL)
    ) u_fifo (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_push        (i_valid),
        .i_pair        (in_pair),
        .i_pop         (pop),
        .o_accept      (push_accept),
        .o_head        (head),
        .o_next_buy0   (next_buy0),
        .o_empty       (fifo_empty),
        .o_almost_full (o_almost_full),
        .o_occ         (fifo_occ)
    );

    // The output registers always hold the word addressed by state_q/idx_q.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tside_d  = tside_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d  = SEND_BUY;
                    idx_d    = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = head.buy[0];
                    tlast_d  = ONE_WORD;
                    tside_d  = 1'b0;
                end
            end
            SEND_BUY: begin
                if (hs && at_last) begin
                    state_d = SEND_SELL;
                    idx_d   = '0;
                    tdata_d = head.sell[0];
                    tlast_d = ONE_WORD;
                    tside_d = 1'b1;
                end else if (hs) begin
                    idx_d   = idx_q + 1'b1;
                    tdata_d = head.buy[idx_d];
                    tlast_d = (idx_d == LAST_IDX);
                end
            end
            SEND_SELL: begin
                if (hs && at_last) begin
                    idx_d   = '0;
                    tlast_d = ONE_WORD;
                    tside_d = 1'b0;
                    // The pair arriving on this very edge is forwarded so the stream has no bubble.
                    if (fifo_occ > OCC_W'(1)) begin
                        state_d = SEND_BUY;
                        tdata_d = next_buy0;
                    end else if (push_accept) begin
                        state_d = SEND_BUY;
                        tdata_d = in_pair.buy[0];
                    end else begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end else if (hs) begin
                    idx_d   = idx_q + 1'b1;
                    tdata_d = head.sell[idx_d];
                    tlast_d = (idx_d == LAST_IDX);
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tside_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tside_q  <= tside_d;
            drop_q   <= i_valid & ~push_accept;
        end
    end

    assign o_tdata      = tdata_q;
    assign o_tvalid     = tvalid_q;
    assign o_tlast      = tlast_q;
    assign o_tside      = tside_q;
    assign o_drop_pulse = drop_q;

`ifdef ORDER_EGRESS_STATS_EN
    logic [31:0] sent_q, dropped_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sent_q    <= '0;
            dropped_q <= '0;
        end else begin
            if (pop && (sent_q != '1)) begin
                sent_q <= sent_q + 32'd1;
            end
            if (i_valid && !push_accept && (dropped_q != '1)) begin
                dropped_q <= dropped_q + 32'd1;
            end
        end
    end

    assign o_pairs_sent    = sent_q;
    assign o_pairs_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_order_egress_serializer.sv
// Bench for order_egress_serializer: queue-based pair model checked every cycle plus directed scenarios.
module tb_order_egress_serializer;
    import hft_egress_pkg::*;

    localparam int W     = 32;
    localparam int NW    = 9;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int MSGB  = NW * W;
    localparam int PAIRB = 2 * MSGB;

    logic            clk = 1'b0;
    logic            rst_n, valid, tready;
    logic [MSGB-1:0] buy, sell;
    logic [W-1:0]    tdata;
    logic            tvalid, tlast, tside, afull, drop;
`ifdef ORDER_EGRESS_STATS_EN
    logic [31:0]     pairs_sent, pairs_dropped;
`endif

    always #5 clk = ~clk;

    order_egress_serializer #(
        .FIFO_DEPTH  (DEPTH),
        .AFULL_LEVEL (AF)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_valid         (valid),
        .i_buy_words     (buy),
        .i_sell_words    (sell),
        .o_tdata         (tdata),
        .o_tvalid        (tvalid),
        .o_tlast         (tlast),
        .o_tside         (tside),
        .i_tready        (tready),
        .o_almost_full   (afull),
        .o_drop_pulse    (drop)
`ifdef ORDER_EGRESS_STATS_EN
        ,
        .o_pairs_sent    (pairs_sent),
        .o_pairs_dropped (pairs_dropped)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted pairs, position of the word on the wire within the head pair.
    logic [PAIRB-1:0] mq[$];
    int               pos        = 0;
    int               occ        = 0;
    int               occ_prev   = 0;
    bit               drop_exp   = 0;
    bit               just_reset = 0;
    bit               prev_stall = 0;
    logic [W+1:0]     prev_out;
    logic [W+1:0]     cap[$];
    int               drops_seen = 0;

    // Word k of the 2*NW-word pair stream as {side, last, data}.
    function automatic logic [W+1:0] exp_word(input logic [PAIRB-1:0] p, input int k);
        logic [MSGB-1:0] b, s;
        logic            side;
        int              w;
        b    = p[PAIRB-1 -: MSGB];
        s    = p[MSGB-1:0];
        side = (k >= NW);
        w    = k % NW;
        return {side, (w == NW - 1), side ? s[w*W +: W] : b[w*W +: W]};
    endfunction

    function automatic logic [MSGB-1:0] make_msg(input logic [W-1:0] base);
        logic [MSGB-1:0] m;
        for (int k = 0; k < NW; k++) m[k*W +: W] = base + W'(k);
        return m;
    endfunction

    always @(negedge clk) begin
        bit exp_valid, hs, popping, acc;
        // A word is on the wire whenever the FIFO held a pair both now and one cycle earlier.
        exp_valid = (occ > 0) && (occ_prev > 0);
        check("tvalid", tvalid, exp_valid);
        check("almost_full", afull, occ >= AF);
        check("drop_pulse", drop, drop_exp);
        if (drop === 1'b1) drops_seen++;
        if (just_reset) begin
            check("reset_out", {tside, tlast, tdata}, '0);
        end
        if (prev_stall) check("hold_stable", {tside, tlast, tdata}, prev_out);
        if (exp_valid) check("word", {tside, tlast, tdata}, exp_word(mq[0], pos));
        hs         = exp_valid && tready;
        prev_stall = exp_valid && !tready;
        prev_out   = {tside, tlast, tdata};
        if (hs) cap.push_back({tside, tlast, tdata});
        if (!rst_n) begin
            mq.delete();
            pos        = 0;
            occ        = 0;
            occ_prev   = 0;
            drop_exp   = 0;
            just_reset = 1;
            prev_stall = 0;
        end else begin
            just_reset = 0;
            popping    = hs && (pos == 2*NW - 1);
            acc        = valid && ((mq.size() < DEPTH) || popping);
            occ_prev   = mq.size();
            if (hs) begin
                if (popping) begin
                    void'(mq.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            if (acc) mq.push_back({buy, sell});
            drop_exp = valid && !acc;
            occ      = mq.size();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [MSGB-1:0] b, input logic [MSGB-1:0] s);
        valid = 1'b1;
        buy   = b;
        sell  = s;
        step();
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        tready = 1'b0;
        valid  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        tready = 1'b1;
        while ((mq.size() != 0 || tvalid !== 1'b0) && n < budget) begin
            step();
            n++;
        end
        check(name, n < budget, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0] pat;
        int         n;

        rst_n  = 1'b0;
        valid  = 1'b0;
        tready = 1'b0;
        buy    = '0;
        sell   = '0;
        step();
        step();
        check("reset_tvalid", tvalid, 1'b0);
        check("reset_tdata", tdata, '0);
        rst_n = 1'b1;
        step();

        // Single pair, ready held high: one-cycle latency, 18 words in order.
        cap.delete();
        tready = 1'b1;
        push_pair(make_msg(32'h100), make_msg(32'h200));
        check("s1_latency_low", tvalid, 1'b0);
        step();
        check("s1_first_valid", tvalid, 1'b1);
        check("s1_first_word", {tside, tlast, tdata}, {1'b0, 1'b0, 32'h100});
        drain("s1_drain_timeout", 100);
        check("s1_count", cap.size(), 18);
        check("s1_buy_last", cap[8], {1'b0, 1'b1, 32'h108});
        check("s1_sell_first", cap[9], {1'b1, 1'b0, 32'h200});
        check("s1_sell_last", cap[17], {1'b1, 1'b1, 32'h208});

        // Back-pressure with a 1,0,0,1 ready pattern and two pairs.
        cap.delete();
        pat = 4'b1001;
        for (int i = 0; i < 200; i++) begin
            tready = pat[i % 4];
            valid  = (i == 0) || (i == 5);
            buy    = make_msg((i == 0) ? 32'h300 : 32'h400);
            sell   = make_msg((i == 0) ? 32'h380 : 32'h480);
            step();
        end
        valid = 1'b0;
        drain("s2_drain_timeout", 100);
        check("s2_count", cap.size(), 36);
        check("s2_pair2_first", cap[18], {1'b0, 1'b0, 32'h400});
        check("s2_pair2_last", cap[35], {1'b1, 1'b1, 32'h488});

        // Overflow: five pairs into a depth-4 FIFO with the sink stalled.
        do_reset();
        cap.delete();
        drops_seen = 0;
        for (int i = 0; i < 5; i++) begin
            push_pair(make_msg(32'h1000 * (i + 1)), make_msg(32'h1000 * (i + 1) + 32'h800));
            check("s3_almost_full", afull, i >= 2);
            check("s3_drop", drop, i == 4);
        end
        drain("s3_drain_timeout", 200);
        check("s3_count", cap.size(), 72);
        check("s3_drops", drops_seen, 1);
        check("s3_last_word", cap[71], {1'b1, 1'b1, 32'h4808});
`ifdef ORDER_EGRESS_STATS_EN
        check("s6_pairs_sent", pairs_sent, 32'd4);
        check("s6_pairs_dropped", pairs_dropped, 32'd1);
`endif

        // Push into a full FIFO on the same edge as the final sell handshake.
        cap.delete();
        drops_seen = 0;
        for (int i = 0; i < 4; i++) push_pair(make_msg(32'h5000 + i * 32'h100), make_msg(32'h5080 + i * 32'h100));
        tready = 1'b1;
        n = 0;
        while (!(tvalid === 1'b1 && tside === 1'b1 && tlast === 1'b1) && n < 100) begin
            step();
            n++;
        end
        check("s4_wait_timeout", n < 100, 1'b1);
        push_pair(make_msg(32'h6000), make_msg(32'h6080));
        check("s4_no_drop", drop, 1'b0);
        check("s4_still_afull", afull, 1'b1);
        drain("s4_drain_timeout", 200);
        check("s4_count", cap.size(), 90);
        check("s4_drops", drops_seen, 0);
        check("s4_new_pair_last", cap[89], {1'b1, 1'b1, 32'h6088});

        // Reset after buy word 4 has been accepted.
        cap.delete();
        tready = 1'b1;
        push_pair(make_msg(32'h700), make_msg(32'h780));
        n = 0;
        while (cap.size() < 5 && n < 50) begin
            step();
            n++;
        end
        check("s5_wait_timeout", n < 50, 1'b1);
        rst_n  = 1'b0;
        tready = 1'b0;
        step();
        check("s5_tvalid_dropped", tvalid, 1'b0);
        rst_n  = 1'b1;
        tready = 1'b1;
        push_pair(make_msg(32'h900), make_msg(32'h980));
        step();
        check("s5_restart_word", {tvalid, tside, tdata}, {1'b1, 1'b0, 32'h900});
        drain("s5_drain_timeout", 100);
        check("s5_count", cap.size(), 5 + 18);
        check("s5_word4", cap[4], {1'b0, 1'b0, 32'h704});

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            valid  = ($urandom_range(0, 3) == 0);
            tready = (i % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rst_n  = ($urandom_range(0, 999) != 0);
            for (int k = 0; k < NW; k++) begin
                buy[k*W +: W]  = $urandom();
                sell[k*W +: W] = $urandom();
            end
            step();
        end
        valid = 1'b0;
        rst_n = 1'b1;
        drain("rand_drain_timeout", 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
